// File: rtl/draw_request_arbiter_if.sv
// Requester-side bus and DrawMif handshake for draw_request_arbiter.
// Slave is the arbiter; master drives requests and the DrawMif ready line.
interface draw_request_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] reqX;
  logic [16*NUM_REQ-1:0] reqY;
  logic [8*NUM_REQ-1:0]  reqMif;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  error;
  logic                  busy;
  logic [15:0]           xOrigin;
  logic [15:0]           yOrigin;
  logic [7:0]            mifId;
  logic                  draw;
  logic                  ready;

  modport slave (
    input  req, reqX, reqY, reqMif, ready,
    output grant, done, error, busy,
    output xOrigin, yOrigin, mifId, draw
  );

  modport master (
    output req, reqX, reqY, reqMif, ready,
    input  grant, done, error, busy,
    input  xOrigin, yOrigin, mifId, draw
  );
endinterface

// File: rtl/draw_request_arbiter.sv
// Round-robin arbiter sharing one DrawMif engine between NUM_REQ
// requesters; latches a command, strobes draw, tracks ready to completion.
module draw_request_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  draw_request_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    WAIT_DONE
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               error_q, error_d;
  logic               draw_q, draw_d;
  logic [15:0]        x_q, x_d;
  logic [15:0]        y_q, y_d;
  logic [7:0]         mif_q, mif_d;

  logic               found;
  logic [PW-1:0]      win;
  int                 win_i;
  int                 idx;
  logic [PW-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0] owner_oh;

  // First requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    win_i = 0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
        win_i = idx;
      end
    end
  end

  always_comb begin
    if (owner_q == PW'(NUM_REQ - 1)) ptr_nxt = '0;
    else ptr_nxt = owner_q + PW'(1);
    owner_oh = NUM_REQ'(1) << owner_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    timer_d = timer_q;
    grant_d = '0;
    done_d  = '0;
    error_d = 1'b0;
    draw_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    mif_d   = mif_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ready && found) begin
          x_d     = bus.reqX[win_i*16 +: 16];
          y_d     = bus.reqY[win_i*16 +: 16];
          mif_d   = bus.reqMif[win_i*8 +: 8];
          grant_d = NUM_REQ'(1) << win;
          draw_d  = 1'b1;
          owner_d = win;
          timer_d = '0;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        // The draw cycle itself is not counted toward the timeout
        if (!bus.ready) begin
          state_d = WAIT_DONE;
        end else if (!draw_q) begin
          if (timer_q == TW'(START_TIMEOUT - 1)) begin
            done_d  = owner_oh;
            error_d = 1'b1;
            ptr_d   = ptr_nxt;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (bus.ready) begin
          done_d  = owner_oh;
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      timer_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      error_q <= 1'b0;
      draw_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      mif_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      error_q <= error_d;
      draw_q  <= draw_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mif_q   <= mif_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.draw    = draw_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.xOrigin = x_q;
  assign bus.yOrigin = y_q;
  assign bus.mifId   = mif_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed bench for draw_request_arbiter with a small DrawMif model.
// Vector table covers arbitration order; hand sequences cover corners.
module tb_draw_request_arbiter;

  localparam int N  = 4;
  localparam int ST = 15;
  localparam int BUSY_LEN = 20;

  logic clk;
  logic rst;

  draw_request_arbiter_if #(.NUM_REQ(N)) bus ();

  draw_request_arbiter #(
    .NUM_REQ(N),
    .START_TIMEOUT(ST)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  mif;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // DrawMif model: mode 0 holds ready at rdy_level, mode 1 auto-runs
  bit m_auto    = 1'b0;
  bit rdy_level = 1'b1;
  int m_st      = 0;
  int m_cnt     = 0;

  always @(negedge clk) begin
    if (!m_auto) begin
      bus.ready = rdy_level;
      m_st = 0;
    end else begin
      case (m_st)
        0: begin
          bus.ready = 1'b1;
          if (bus.draw) m_st = 1;
        end
        1: begin
          bus.ready = 1'b0;
          m_cnt = BUSY_LEN;
          m_st = 2;
        end
        default: begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            bus.ready = 1'b1;
            m_st = 0;
          end
        end
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.grant, bus.done, bus.error, bus.busy,
                bus.draw, bus.xOrigin, bus.yOrigin, bus.mifId});
  endfunction

  task automatic set_ops;
    bus.reqX   = {16'd1234, 16'd100, 16'd300, 16'd10};
    bus.reqY   = {16'd567, 16'd50, 16'd400, 16'd20};
    bus.reqMif = {8'd255, 8'd3, 8'd7, 8'd1};
  endtask

  task automatic chk_ops(input string tag, input vec_t v);
    check({tag, "_x"}, 64'(bus.xOrigin), 64'(v.x));
    check({tag, "_y"}, 64'(bus.yOrigin), 64'(v.y));
    check({tag, "_mif"}, 64'(bus.mifId), 64'(v.mif));
  endtask

  // Present a request, expect grant next cycle, then completion
  task automatic run_vec(input vec_t v);
    logic rp, rn, bp, bn;
    bit seen;
    bus.req = v.req;
    tick;
    check("grant", 64'(bus.grant), 64'(v.grant));
    check("draw", 64'(bus.draw), 64'd1);
    check("done_idle", 64'(bus.done), 64'd0);
    chk_ops("grant", v);
    bus.req = v.req & ~v.grant;
    tick;
    check("pulse_w", 64'({bus.grant, bus.draw}), 64'd0);
    check("busy", 64'(bus.busy), 64'd1);
    rn = bus.ready;
    bn = bus.busy;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      rp = rn;
      bp = bn;
      tick;
      rn = bus.ready;
      bn = bus.busy;
      if (bus.done != 0) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("done", 64'(bus.done), 64'(v.grant));
    check("done_err", 64'(bus.error), 64'd0);
    check("done_rdy", 64'({rp, rn}), 64'b01);
    check("done_busy", 64'({bp, bn}), 64'b10);
    chk_ops("done", v);
  endtask

  vec_t vecs[11];
  vec_t v;
  bit bad;

  initial begin
    vecs[0]  = '{4'b1111, 4'b0001, 16'd10, 16'd20, 8'd1};
    vecs[1]  = '{4'b1110, 4'b0010, 16'd300, 16'd400, 8'd7};
    vecs[2]  = '{4'b1100, 4'b0100, 16'd100, 16'd50, 8'd3};
    vecs[3]  = '{4'b1000, 4'b1000, 16'd1234, 16'd567, 8'd255};
    vecs[4]  = '{4'b1010, 4'b0010, 16'd300, 16'd400, 8'd7};
    vecs[5]  = '{4'b1000, 4'b1000, 16'd1234, 16'd567, 8'd255};
    vecs[6]  = '{4'b0011, 4'b0001, 16'd10, 16'd20, 8'd1};
    vecs[7]  = '{4'b0011, 4'b0010, 16'd300, 16'd400, 8'd7};
    vecs[8]  = '{4'b0011, 4'b0001, 16'd10, 16'd20, 8'd1};
    vecs[9]  = '{4'b0011, 4'b0010, 16'd300, 16'd400, 8'd7};
    vecs[10] = '{4'b0100, 4'b0100, 16'd100, 16'd50, 8'd3};

    // Reset with random inputs
    rst = 1'b1;
    bus.req = '0;
    set_ops;
    for (int i = 0; i < 5; i++) begin
      bus.req    = 4'($urandom);
      bus.reqX   = {$urandom, $urandom};
      bus.reqY   = {$urandom, $urandom};
      bus.reqMif = $urandom;
      rdy_level  = 1'($urandom);
      tick;
      check("reset_outs", outs(), 64'd0);
    end
    rst = 1'b0;
    bus.req = '0;
    set_ops;
    rdy_level = 1'b1;
    m_auto = 1'b1;
    tick;
    check("post_reset", outs(), 64'd0);
    tick;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Ready gating, then start timeout on the same command
    m_auto = 1'b0;
    rdy_level = 1'b0;
    tick;
    bus.req = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      tick;
      check("gate", 64'({bus.grant, bus.draw, bus.busy}), 64'd0);
    end
    rdy_level = 1'b1;
    tick;
    check("gate_grant", 64'(bus.grant), 64'b0001);
    check("gate_draw", 64'(bus.draw), 64'd1);
    bus.req = '0;
    for (int j = 1; j <= ST; j++) begin
      tick;
      check("to_wait", 64'({bus.done, bus.error, bus.busy}), 64'd1);
    end
    tick;
    check("to_done", 64'(bus.done), 64'b0001);
    check("to_err", 64'(bus.error), 64'd1);
    check("to_busy", 64'(bus.busy), 64'd0);
    tick;
    check("to_pulse", 64'({bus.done, bus.error}), 64'd0);

    // ptr advanced past owner 0
    m_auto = 1'b1;
    tick;
    v = '{4'b1111, 4'b0010, 16'd300, 16'd400, 8'd7};
    run_vec(v);

    // Reset in WAIT_DONE aborts silently and clears ptr
    bus.req = 4'b1000;
    tick;
    check("rst_grant", 64'(bus.grant), 64'b1000);
    bus.req = '0;
    for (int i = 0; i < 10; i++) tick;
    check("rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick;
    check("rst_mid", outs(), 64'd0);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.done != 0 || bus.error) bad = 1'b1;
    end
    check("rst_no_done", 64'(bad), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd1);
    v = '{4'b1111, 4'b0001, 16'd10, 16'd20, 8'd1};
    run_vec(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
